// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-beat valid/ready commands into complete
// AXI4-Lite write or read transactions, one at a time, and returns each completion.
module axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 256
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int CW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RSP} state_t;

    state_t        state;
    logic          aw_done;
    logic          w_done;
    logic [CW-1:0] to_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting;

    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid  && m_axi_wready;
    assign b_hs    = m_axi_bvalid  && m_axi_bready;
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign r_hs    = m_axi_rvalid  && m_axi_rready;
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign waiting = (state == WRITE) || (state == WRESP) || (state == RADDR) || (state == RDATA);

    // NOTE: every output is a flop updated with <= so all of them change together
    // on the edge; cmd_ready is 0 in reset and rises on the first clock after release.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            to_cnt        <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            timeout       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WRITE;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                WRITE: begin
                    // Address and data channels complete independently, in either order.
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WRESP;
                    end
                end

                WRESP: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RADDR: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RDATA;
                    end
                end

                RDATA: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Stall watchdog: only reports, the transaction keeps waiting.
            if (waiting) begin
                if (any_hs) begin
                    to_cnt <= '0;
                end else if (C_TIMEOUT != 0 && to_cnt == CNT_LAST) begin
                    to_cnt  <= '0;
                    timeout <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a small register-file slave with tunable
// per-channel latencies, a transaction-rule model compared every cycle, and literal checks.
module tb_axi_lite_master;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT(TO)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .timeout(timeout),
        .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Handshake monitor and slave register file
    int unsigned   cyc = 0;
    int            n_aw, n_w, n_b, n_ar, n_r;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [SW-1:0] last_wstrb;
    logic [DW-1:0] mem [0:127];
    logic [1:0]    bresp_cfg = 2'b00;
    logic [1:0]    rresp_cfg = 2'b00;
    int            aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    int unsigned   to_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                n_aw        <= n_aw + 1;
                last_awaddr <= m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                n_w        <= n_w + 1;
                last_wdata <= m_axi_wdata;
                last_wstrb <= m_axi_wstrb;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                n_b <= n_b + 1;
                if (bresp_cfg == 2'b00)
                    for (int i = 0; i < SW; i++)
                        if (last_wstrb[i]) mem[last_awaddr[8:2]][8*i +: 8] <= last_wdata[8*i +: 8];
            end
            if (m_axi_arvalid && m_axi_arready) begin
                n_ar        <= n_ar + 1;
                last_araddr <= m_axi_araddr;
            end
            if (m_axi_rvalid && m_axi_rready) n_r <= n_r + 1;
        end
    end

    always @(negedge clk) if (timeout === 1'b1) to_times.push_back(cyc);

    // Slave responder: drives its inputs on the falling edge.
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
            m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = '0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_wait >= aw_lat);
                if (!m_axi_awready) aw_wait++;
            end else begin
                m_axi_awready = 1'b0; aw_wait = 0;
            end
            if (m_axi_wvalid) begin
                m_axi_wready = (w_wait >= w_lat);
                if (!m_axi_wready) w_wait++;
            end else begin
                m_axi_wready = 1'b0; w_wait = 0;
            end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_wait >= ar_lat);
                if (!m_axi_arready) ar_wait++;
            end else begin
                m_axi_arready = 1'b0; ar_wait = 0;
            end
            if (n_aw > n_b && n_w > n_b) begin
                m_axi_bvalid = (b_wait >= b_lat);
                m_axi_bresp  = bresp_cfg;
                if (!m_axi_bvalid) b_wait++;
            end else begin
                m_axi_bvalid = 1'b0; b_wait = 0;
            end
            if (n_ar > n_r) begin
                m_axi_rvalid = (r_wait >= r_lat);
                m_axi_rdata  = mem[last_araddr[8:2]];
                m_axi_rresp  = rresp_cfg;
                if (!m_axi_rvalid) r_wait++;
            end else begin
                m_axi_rvalid = 1'b0; r_wait = 0;
            end
        end
    end

    // Behavioural model: what each output must be, from the handshake rules.
    logic          exp_cmd_ready, exp_awvalid, exp_wvalid, exp_bready;
    logic          exp_arvalid, exp_rready, exp_rsp_valid, exp_rsp_write, exp_timeout;
    logic [AW-1:0] exp_awaddr, exp_araddr;
    logic [DW-1:0] exp_wdata, exp_rsp_rdata;
    logic [SW-1:0] exp_wstrb;
    logic [1:0]    exp_rsp_resp;
    int            stall_cycles;

    logic m_hs_aw, m_hs_w, m_hs_b, m_hs_ar, m_hs_r, m_any_hs, m_waiting, m_busy;
    assign m_hs_aw   = exp_awvalid && m_axi_awready;
    assign m_hs_w    = exp_wvalid  && m_axi_wready;
    assign m_hs_b    = exp_bready  && m_axi_bvalid;
    assign m_hs_ar   = exp_arvalid && m_axi_arready;
    assign m_hs_r    = exp_rready  && m_axi_rvalid;
    assign m_any_hs  = m_hs_aw || m_hs_w || m_hs_b || m_hs_ar || m_hs_r;
    assign m_waiting = exp_awvalid || exp_wvalid || exp_bready || exp_arvalid || exp_rready;
    assign m_busy    = m_waiting || exp_rsp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cmd_ready <= 1'b0; exp_awvalid <= 1'b0; exp_wvalid <= 1'b0;
            exp_bready    <= 1'b0; exp_arvalid <= 1'b0; exp_rready <= 1'b0;
            exp_rsp_valid <= 1'b0; exp_rsp_write <= 1'b0; exp_timeout <= 1'b0;
            exp_awaddr    <= '0; exp_araddr <= '0; exp_wdata <= '0; exp_wstrb <= '0;
            exp_rsp_rdata <= '0; exp_rsp_resp <= 2'b00; stall_cycles <= 0;
        end else begin
            exp_timeout <= 1'b0;
            if (cmd_valid && exp_cmd_ready) begin
                exp_cmd_ready <= 1'b0;
                exp_rsp_write <= cmd_write;
                if (cmd_write) begin
                    exp_awvalid <= 1'b1; exp_wvalid <= 1'b1;
                    exp_awaddr  <= cmd_addr; exp_wdata <= cmd_wdata; exp_wstrb <= cmd_wstrb;
                end else begin
                    exp_arvalid <= 1'b1; exp_araddr <= cmd_addr;
                end
            end else if (!m_busy) begin
                exp_cmd_ready <= 1'b1;
            end
            if (m_hs_aw) exp_awvalid <= 1'b0;
            if (m_hs_w)  exp_wvalid  <= 1'b0;
            if ((exp_awvalid || exp_wvalid) && (!exp_awvalid || m_hs_aw) && (!exp_wvalid || m_hs_w))
                exp_bready <= 1'b1;
            if (m_hs_b) begin
                exp_bready <= 1'b0; exp_rsp_valid <= 1'b1;
                exp_rsp_resp <= m_axi_bresp; exp_rsp_rdata <= '0;
            end
            if (m_hs_ar) begin
                exp_arvalid <= 1'b0; exp_rready <= 1'b1;
            end
            if (m_hs_r) begin
                exp_rready <= 1'b0; exp_rsp_valid <= 1'b1;
                exp_rsp_resp <= m_axi_rresp; exp_rsp_rdata <= m_axi_rdata;
            end
            if (exp_rsp_valid && rsp_ready) begin
                exp_rsp_valid <= 1'b0; exp_cmd_ready <= 1'b1;
            end
            // Every TO consecutive stalled cycles produce one pulse.
            if (!m_waiting || m_any_hs) begin
                stall_cycles <= 0;
            end else if (stall_cycles + 1 == TO) begin
                stall_cycles <= 0; exp_timeout <= 1'b1;
            end else begin
                stall_cycles <= stall_cycles + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cmd_ready", cmd_ready, exp_cmd_ready);
        check("awvalid", m_axi_awvalid, exp_awvalid);
        check("wvalid", m_axi_wvalid, exp_wvalid);
        check("bready", m_axi_bready, exp_bready);
        check("arvalid", m_axi_arvalid, exp_arvalid);
        check("rready", m_axi_rready, exp_rready);
        check("rsp_valid", rsp_valid, exp_rsp_valid);
        check("timeout", timeout, exp_timeout);
        if (exp_awvalid) check("awaddr", m_axi_awaddr, exp_awaddr);
        if (exp_wvalid) begin
            check("wdata", m_axi_wdata, exp_wdata);
            check("wstrb", m_axi_wstrb, exp_wstrb);
        end
        if (exp_arvalid) check("araddr", m_axi_araddr, exp_araddr);
        if (exp_rsp_valid) begin
            check("rsp_write", rsp_write, exp_rsp_write);
            check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
            check("rsp_resp", rsp_resp, exp_rsp_resp);
        end
    end

    task automatic accept(output int unsigned t);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        t = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, output int unsigned t);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        accept(t);
    endtask

    task automatic wait_rsp(output logic w, output logic [DW-1:0] rd, output logic [1:0] rs);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", rsp_valid, 1);
        w = rsp_write; rd = rsp_rdata; rs = rsp_resp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   t0;
        logic          w;
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            aw0, w0, b0, ar0;

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst cmd_ready", cmd_ready, 0);
        check("rst awvalid", m_axi_awvalid, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst awaddr", m_axi_awaddr, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready after reset", cmd_ready, 1);

        // Write then read-back
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        issue(1'b1, 9'h004, 32'h39AF1292, 4'hF, t0);
        wait_rsp(w, rd, rs);
        check("wr awaddr", last_awaddr, 9'h004);
        check("wr aw count", n_aw - aw0, 1);
        check("wr w count", n_w - w0, 1);
        check("wr b count", n_b - b0, 1);
        check("wr rsp_write", w, 1);
        check("wr rsp_resp", rs, 0);
        check("wr rsp_rdata", rd, 0);
        issue(1'b0, 9'h004, '0, '0, t0);
        wait_rsp(w, rd, rs);
        check("rd araddr", last_araddr, 9'h004);
        check("rd rsp_write", w, 0);
        check("rd rsp_rdata", rd, 32'h39AF1292);
        check("rd rsp_resp", rs, 0);

        // Channel skew: data late, then address late (with partial strobes)
        aw_lat = 0; w_lat = 3; b0 = n_b;
        issue(1'b1, 9'h008, 32'hA5A55A5A, 4'hF, t0);
        wait_rsp(w, rd, rs);
        check("skew1 b count", n_b - b0, 1);
        check("skew1 rsp_resp", rs, 0);
        aw_lat = 3; w_lat = 0; b0 = n_b;
        issue(1'b1, 9'h008, 32'h1234C3C3, 4'h3, t0);
        wait_rsp(w, rd, rs);
        check("skew2 b count", n_b - b0, 1);
        check("skew2 rsp_write", w, 1);
        aw_lat = 0;
        issue(1'b0, 9'h008, '0, '0, t0);
        wait_rsp(w, rd, rs);
        check("skew readback", rd, 32'hA5A5C3C3);

        // Backpressure on the response port with the next command already waiting
        issue(1'b1, 9'h00C, 32'h0BADF00D, 4'hF, t0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h00C;
        for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
        ar0 = n_ar; aw0 = n_aw;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp rsp_valid", rsp_valid, 1);
            check("bp rsp_write", rsp_write, 1);
            check("bp rsp_resp", rsp_resp, 0);
            check("bp rsp_rdata", rsp_rdata, 0);
            check("bp cmd_ready", cmd_ready, 0);
            check("bp arvalid", m_axi_arvalid, 0);
        end
        check("bp no ar", n_ar - ar0, 0);
        check("bp no aw", n_aw - aw0, 0);
        rsp_ready = 1'b1;
        accept(t0);
        wait_rsp(w, rd, rs);
        check("bp read rdata", rd, 32'h0BADF00D);
        check("bp read count", n_ar - ar0, 1);

        // Address-channel stall long enough for two timeout pulses
        ar_lat = 20;
        to_times.delete();
        issue(1'b0, 9'h004, '0, '0, t0);
        wait_rsp(w, rd, rs);
        ar_lat = 0;
        check("timeout pulses", to_times.size(), 2);
        if (to_times.size() == 2) begin
            check("timeout first", to_times[0] - t0, 8);
            check("timeout second", to_times[1] - t0, 16);
        end
        check("timeout rdata", rd, 32'h39AF1292);
        check("timeout rresp", rs, 0);

        // Error responses pass through unchanged
        bresp_cfg = 2'b10;
        issue(1'b1, 9'h010, 32'h11111111, 4'hF, t0);
        wait_rsp(w, rd, rs);
        check("slverr bresp", rs, 2);
        check("slverr rsp_write", w, 1);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11;
        issue(1'b0, 9'h004, '0, '0, t0);
        wait_rsp(w, rd, rs);
        check("decerr rresp", rs, 3);
        check("decerr rdata", rd, 32'h39AF1292);
        rresp_cfg = 2'b00;

        // Reset in the middle of a stalled write
        aw_lat = 10; w_lat = 10;
        issue(1'b1, 9'h014, 32'hDEADBEEF, 4'hF, t0);
        @(negedge clk);
        check("mid awvalid high", m_axi_awvalid, 1);
        check("mid wvalid high", m_axi_wvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst awvalid", m_axi_awvalid, 0);
        check("mid rst wvalid", m_axi_wvalid, 0);
        check("mid rst rsp_valid", rsp_valid, 0);
        check("mid rst cmd_ready", cmd_ready, 0);
        @(negedge clk);
        aw_lat = 0; w_lat = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst cmd_ready", cmd_ready, 1);
        check("post rst rsp_valid", rsp_valid, 0);
        issue(1'b0, 9'h004, '0, '0, t0);
        wait_rsp(w, rd, rs);
        check("post rst rdata", rd, 32'h39AF1292);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
